stream_deserializer: RTL and testbench

STREAM_DESERIALIZER -- requirements
Module: stream_deserializer

---
 rtl/stream_deserializer.sv | 150 +++++++++++++++
 tb/tb_stream_deserializer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_deserializer.sv
// Stream deserializer: gathers N serialized samples into one N-channel frame with independent per-channel handshakes.
// Optional tid/tlast framing checks are compiled in when STREAM_DESERIALIZER_TID_CHECK_EN is defined.
module stream_deserializer #(
  parameter int DW   = 24,
  parameter int N    = 4,
  parameter int TIDW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  input  logic [TIDW-1:0] s_axis_tid,
  input  logic            s_axis_tlast,
  output logic [DW-1:0]   m_axis_tdata [N],
  output logic [N-1:0]    m_axis_tvalid,
  input  logic [N-1:0]    m_axis_tready,
  output logic            frame_err,
  output logic [15:0]     err_count
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] ctr_r;
  logic [DW-1:0] cap_r [N];

  logic accept_s;
  logic last_s;
  logic drain_ok_s;
  logic xfer_s;
  logic err_s;

  // Handshake decode; the transfer may coincide with the final pending output handshake.
  always_comb begin
    accept_s   = s_axis_tvalid && s_axis_tready;
    last_s     = (ctr_r == LAST_IDX);
    drain_ok_s = ((m_axis_tvalid & ~m_axis_tready) == {N{1'b0}});
    xfer_s     = (state_r == HOLD) && drain_ok_s;
  end

`ifdef STREAM_DESERIALIZER_TID_CHECK_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  // A collected sample must carry its slot index as tid and tlast only on the final slot.
  always_comb begin
    err_s = accept_s && (state_r == COLLECT) &&
            ((s_axis_tid != TIDW'(ctr_r)) || (s_axis_tlast != last_s));
  end

  // Registered error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_count <= 16'h0000;
    end else begin
      frame_err <= err_s;
      if (err_s) begin
        err_count <= sat_inc(err_count);
      end
    end
  end
`else
  logic unused_s;

  assign err_s     = 1'b0;
  assign frame_err = 1'b0;
  assign err_count = 16'h0000;
  assign unused_s  = &{1'b0, s_axis_tid};
`endif

  // Control FSM with registered tready and per-channel output valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= COLLECT;
      ctr_r         <= {CW{1'b0}};
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= {N{1'b0}};
    end else begin
      if (xfer_s) begin
        m_axis_tvalid <= {N{1'b1}};
      end else begin
        m_axis_tvalid <= m_axis_tvalid & ~m_axis_tready;
      end
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            if (err_s) begin
              ctr_r   <= {CW{1'b0}};
              state_r <= s_axis_tlast ? COLLECT : DISCARD;
            end else if (last_s) begin
              ctr_r         <= {CW{1'b0}};
              state_r       <= HOLD;
              s_axis_tready <= 1'b0;
            end else begin
              ctr_r <= ctr_r + CW'(1);
            end
          end
        end
        HOLD: begin
          if (xfer_s) begin
            state_r       <= COLLECT;
            s_axis_tready <= 1'b1;
          end
        end
        DISCARD: begin
          if (accept_s && s_axis_tlast) begin
            state_r <= COLLECT;
            ctr_r   <= {CW{1'b0}};
          end
        end
        default: begin
          state_r       <= COLLECT;
          ctr_r         <= {CW{1'b0}};
          s_axis_tready <= 1'b1;
        end
      endcase
    end
  end

  // Capture buffer; kept separate from the output registers so the next frame can fill while outputs drain.
  always_ff @(posedge clk) begin
    if ((state_r == COLLECT) && accept_s && !err_s) begin
      cap_r[ctr_r] <= s_axis_tdata;
    end
  end

  // Output data registers load only on transfer, so they stay stable while valid.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      for (int i = 0; i < N; i++) begin
        m_axis_tdata[i] <= cap_r[i];
      end
    end
  end

endmodule

// File: tb/tb_stream_deserializer.sv
// Self-checking bench for stream_deserializer: directed scenarios plus randomized traffic
// scored against a frame-level queue model.
module tb_stream_deserializer;

  localparam int DW   = 24;
  localparam int N    = 4;
  localparam int TIDW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   s_axis_tdata = '0;
  logic            s_axis_tvalid = 1'b0;
  logic            s_axis_tready;
  logic [TIDW-1:0] s_axis_tid = '0;
  logic            s_axis_tlast = 1'b0;
  logic [DW-1:0]   m_axis_tdata [N];
  logic [N-1:0]    m_axis_tvalid;
  logic [N-1:0]    m_axis_tready = '1;
  logic            frame_err;
  logic [15:0]     err_count;

  stream_deserializer #(.DW(DW), .N(N), .TIDW(TIDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_err     (frame_err),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frames are completed from accepted samples, then queued per channel.
  logic [DW-1:0] exp_q [N][$];
  logic [DW-1:0] cur_q [$];
  bit            m_discard = 1'b0;
  bit            err_exp   = 1'b0;
  int            err_cnt_m = 0;
  logic [N-1:0]  hold_chk  = '0;
  logic [DW-1:0] hold_data [N];

  logic [N-1:0]  obs_valid;
  logic          obs_tready;
  logic [DW-1:0] obs_data [N];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_sample(input logic [DW-1:0] d);
    cur_q.push_back(d);
    if (cur_q.size() == N) begin
      for (int i = 0; i < N; i++) exp_q[i].push_back(cur_q[i]);
      cur_q.delete();
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic [TIDW-1:0] id, input logic last);
`ifdef STREAM_DESERIALIZER_TID_CHECK_EN
    int pos;
    if (m_discard) begin
      if (last) m_discard = 1'b0;
    end else begin
      pos = cur_q.size();
      if ((int'(id) != pos) || (last != (pos == N - 1))) begin
        err_exp = 1'b1;
        if (err_cnt_m < 65535) err_cnt_m++;
        cur_q.delete();
        m_discard = !last;
      end else begin
        push_sample(d);
      end
    end
`else
    push_sample(d);
`endif
  endtask

  task automatic do_cycle(input logic v, input logic [DW-1:0] d, input logic [TIDW-1:0] id,
                          input logic last, input logic [N-1:0] mr);
    logic [DW-1:0] exp_d;
    @(negedge clk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tid    = id;
    s_axis_tlast  = last;
    m_axis_tready = mr;
    obs_valid  = m_axis_tvalid;
    obs_tready = s_axis_tready;
    for (int i = 0; i < N; i++) obs_data[i] = m_axis_tdata[i];
    check_eq("frame_err", 64'(frame_err), 64'(err_exp));
    check_eq("err_count", 64'(err_count), 64'(err_cnt_m));
    for (int i = 0; i < N; i++) begin
      if (hold_chk[i]) begin
        check_eq("hold_valid", 64'(m_axis_tvalid[i]), 64'(1'b1));
        check_eq("hold_data", 64'(m_axis_tdata[i]), 64'(hold_data[i]));
      end
      if (m_axis_tvalid[i] && mr[i]) begin
        check_eq("out_expected", 64'(exp_q[i].size() > 0), 64'(1'b1));
        if (exp_q[i].size() > 0) begin
          exp_d = exp_q[i].pop_front();
          check_eq("out_data", 64'(m_axis_tdata[i]), 64'(exp_d));
        end
      end
      hold_chk[i]  = m_axis_tvalid[i] && !mr[i];
      hold_data[i] = m_axis_tdata[i];
    end
    err_exp = 1'b0;
    if (v && s_axis_tready) model_accept(d, id, last);
  endtask

  task automatic idle(input int n, input logic [N-1:0] mr);
    for (int k = 0; k < n; k++) do_cycle(1'b0, '0, '0, 1'b0, mr);
  endtask

  // Reset with a valid sample pending to show reset wins over the handshake.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(24'hABCDEF);
    m_axis_tready = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    cur_q.delete();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    m_discard = 1'b0;
    err_exp   = 1'b0;
    err_cnt_m = 0;
    hold_chk  = '0;
    @(negedge clk);
    check_eq("rst_tready", 64'(s_axis_tready), 64'(1'b1));
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check_eq("rst_frame_err", 64'(frame_err), 64'(0));
    check_eq("rst_err_count", 64'(err_count), 64'(0));
  endtask

  task automatic send_frame(input int base, input int step, input logic [N-1:0] mr);
    for (int i = 0; i < N; i++)
      do_cycle(1'b1, DW'(base + step * i), TIDW'(i), (i == N - 1), mr);
  endtask

  initial begin
    do_reset();

    // Basic frame with idle outputs: two-cycle latency.
    send_frame(10, 10, 4'b1111);
    do_cycle(1'b0, '0, '0, 1'b0, 4'b1111);
    check_eq("lat_hold_valid", 64'(obs_valid), 64'(0));
    check_eq("lat_hold_tready", 64'(obs_tready), 64'(0));
    do_cycle(1'b0, '0, '0, 1'b0, 4'b1111);
    check_eq("lat_valid", 64'(obs_valid), 64'(4'b1111));
    for (int i = 0; i < N; i++) check_eq("lat_data", 64'(obs_data[i]), 64'(10 * (i + 1)));
    idle(2, 4'b1111);

    // Channel 2 back-pressured while a second frame fills.
    send_frame(11, 1, 4'b1011);
    idle(3, 4'b1011);
    send_frame(1, 1, 4'b1011);
    idle(2, 4'b1011);
    check_eq("hold_tready", 64'(obs_tready), 64'(0));
    check_eq("hold_pending", 64'(obs_valid), 64'(4'b0100));
    do_cycle(1'b0, '0, '0, 1'b0, 4'b1111);
    do_cycle(1'b0, '0, '0, 1'b0, 4'b0000);
    check_eq("xfer_valid", 64'(obs_valid), 64'(4'b1111));
    for (int i = 0; i < N; i++) check_eq("xfer_data", 64'(obs_data[i]), 64'(i + 1));
    idle(3, 4'b1111);

    // Reset mid-frame abandons the partial frame.
    do_cycle(1'b1, DW'(77), TIDW'(0), 1'b0, 4'b1111);
    do_cycle(1'b1, DW'(78), TIDW'(1), 1'b0, 4'b1111);
    do_reset();
    idle(4, 4'b1111);
    check_eq("rst_no_valid", 64'(obs_valid), 64'(0));
    send_frame(9, 0, 4'b1111);
    idle(2, 4'b1111);
    check_eq("frame9_valid", 64'(obs_valid), 64'(4'b1111));
    for (int i = 0; i < N; i++) check_eq("frame9_data", 64'(obs_data[i]), 64'(9));
    idle(2, 4'b1111);

`ifdef STREAM_DESERIALIZER_TID_CHECK_EN
    // Wrong tid: discard until tlast, then a clean frame.
    do_cycle(1'b1, DW'(50), TIDW'(0), 1'b0, 4'b1111);
    do_cycle(1'b1, DW'(51), TIDW'(2), 1'b0, 4'b1111);
    do_cycle(1'b1, DW'(52), TIDW'(1), 1'b0, 4'b1111);
    check_eq("tid_err_pulse", 64'(frame_err), 64'(1'b1));
    do_cycle(1'b1, DW'(53), TIDW'(3), 1'b1, 4'b1111);
    check_eq("tid_err_count", 64'(err_count), 64'(1));
    send_frame(5, 1, 4'b1111);
    idle(4, 4'b1111);
    // Early tlast: no discard phase.
    do_cycle(1'b1, DW'(60), TIDW'(0), 1'b0, 4'b1111);
    do_cycle(1'b1, DW'(61), TIDW'(1), 1'b1, 4'b1111);
    send_frame(70, 1, 4'b1111);
    idle(4, 4'b1111);
    check_eq("early_last_count", 64'(err_count), 64'(2));
`else
    // Count-only framing: tid/tlast ignored, two frames in order.
    for (int k = 0; k < 2 * N; k++)
      do_cycle(1'b1, DW'(100 + k), TIDW'(0), 1'b0, 4'b1111);
    idle(4, 4'b1111);
    check_eq("count_only_err", 64'(frame_err), 64'(0));
`endif

    // Randomized traffic with occasional framing corruption and back-pressure.
    for (int k = 0; k < 800; k++) begin
      logic [N-1:0] mr;
      logic [TIDW-1:0] id;
      logic last;
      if (k == 400) do_reset();
      for (int i = 0; i < N; i++) mr[i] = ($urandom_range(0, 9) < 7);
      id   = TIDW'(cur_q.size());
      last = (cur_q.size() == N - 1);
      if ($urandom_range(0, 15) == 0) id = TIDW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 19) == 0) last = !last;
      do_cycle($urandom_range(0, 3) != 0, DW'($urandom), id, last, mr);
    end

    idle(20, 4'b1111);
    for (int i = 0; i < N; i++) check_eq("leftover", 64'(exp_q[i].size()), 64'(0));
    check_eq("final_valid", 64'(obs_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
